twos_to_signmag: RTL and testbench

TWOS_TO_SIGNMAG -- requirements
Module: twos_to_signmag

---
 rtl/twos_to_signmag.sv | 123 ++++++++++++
 tb/tb_twos_to_signmag.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag.sv
// ----------------------------------------------------------------------------
// twos_to_signmag
//   Serial two's-complement to sign-magnitude converter. An operand is
//   captured in IDLE, walked LSB first through a shift register for WIDTH
//   cycles (copy bits for positives, serial negation for negatives), then
//   held in DONE until the consumer takes it.
//
//   Optional feature: define TWOS_TO_SIGNMAG_SAT_EN to saturate the
//   most-negative operand to -(2^(WIDTH-1)-1) instead of raw truncation.
//
// Ports
//   CLK        rising-edge clock
//   RESET      synchronous active-low reset
//   DATA_IN    two's-complement operand
//   IN_VALID   DATA_IN valid (sampled only in IDLE)
//   IN_READY   block can accept an operand (IDLE)
//   DATA_OUT   sign-magnitude result {sign, magnitude[WIDTH-2:0]}
//   OVF        operand was the most-negative value
//   OUT_VALID  DATA_OUT / OVF valid
//   OUT_READY  consumer accepts the result
// ----------------------------------------------------------------------------
module twos_to_signmag #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] DATA_OUT,
   output logic             OVF,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh;        // operand bits out at [0], result bits in at MSB
   logic             sign;
   logic             seen_one;
   logic [CW-1:0]    cnt;

   logic             last;
   logic             in_bit;
   logic             obit;
   logic             ovf_nxt;
   logic [WIDTH-1:0] dout_nxt;

   assign last   = (cnt == CW'(WIDTH-1));
   assign in_bit = sh[0];
   // Serial negation: pass bits up to and including the first 1, invert the rest.
   assign obit   = sign ? (in_bit ^ seen_one) : in_bit;

   // After WIDTH shifts sh holds |operand| as a WIDTH-bit value. Only the
   // most-negative operand maps back onto MOST_NEG, i.e. a zero magnitude
   // field with the sign set.
   assign ovf_nxt = sign && (sh == MOST_NEG);

`ifdef TWOS_TO_SIGNMAG_SAT_EN
   assign dout_nxt = ovf_nxt ? {WIDTH{1'b1}} : {sign, sh[WIDTH-2:0]};
`else
   assign dout_nxt = {sign, sh[WIDTH-2:0]};
`endif

   assign IN_READY = (state == IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (IN_VALID)               state_nxt = SHIFT;
         SHIFT:   if (last)                   state_nxt = DONE;
         DONE:    if (OUT_VALID && OUT_READY) state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state     <= IDLE;
         sh        <= '0;
         sign      <= 1'b0;
         seen_one  <= 1'b0;
         cnt       <= '0;
         DATA_OUT  <= '0;
         OVF       <= 1'b0;
         OUT_VALID <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  sh       <= DATA_IN;
                  sign     <= DATA_IN[WIDTH-1];
                  seen_one <= 1'b0;
                  cnt      <= '0;
               end
            end
            SHIFT: begin
               sh       <= {obit, sh[WIDTH-1:1]};
               seen_one <= seen_one | in_bit;
               cnt      <= last ? '0 : cnt + 1'b1;
            end
            DONE: begin
               // First DONE cycle finalizes the result; it then stays put
               // until the consumer accepts it.
               if (!OUT_VALID) begin
                  DATA_OUT  <= dout_nxt;
                  OVF       <= ovf_nxt;
                  OUT_VALID <= 1'b1;
               end else if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_twos_to_signmag.sv
// ----------------------------------------------------------------------------
// tb_twos_to_signmag
//   Directed + randomized bench for twos_to_signmag (WIDTH=8). Expected
//   results come from an arithmetic model: value = signed operand, result =
//   {value<0, |value|}, with the most-negative operand flagged and either
//   truncated or saturated depending on TWOS_TO_SIGNMAG_SAT_EN.
// ----------------------------------------------------------------------------
module tb_twos_to_signmag;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [W-1:0] DATA_IN;
   logic         IN_VALID;
   logic         IN_READY;
   logic [W-1:0] DATA_OUT;
   logic         OVF;
   logic         OUT_VALID;
   logic         OUT_READY;

   int n_checks = 0;
   int n_fail   = 0;

   twos_to_signmag #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .DATA_IN   (DATA_IN),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .DATA_OUT  (DATA_OUT),
      .OVF       (OVF),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {ovf, data_out} from plain signed arithmetic
   function automatic logic [W:0] model(input logic [W-1:0] x);
      int         v;
      int         mag;
      logic       s;
      logic       ovf;
      logic [W-2:0] m;
      v   = x[W-1] ? int'(x) - (1 << W) : int'(x);
      s   = (v < 0);
      mag = s ? -v : v;
      ovf = 1'b0;
      if (mag > (1 << (W-1)) - 1) begin
         ovf = 1'b1;
`ifdef TWOS_TO_SIGNMAG_SAT_EN
         mag = (1 << (W-1)) - 1;
`else
         mag = 0;
`endif
      end
      m = mag[W-2:0];
      return {ovf, s, m};
   endfunction

   // One full transaction: capture, latency check, result check, optional
   // backpressure for `hold` cycles with a stray IN_VALID, then release.
   task automatic run_op(input logic [W-1:0] d, input int hold, input string tag);
      int           k;
      logic [W:0]   exp;
      logic [W-1:0] held;
      exp       = model(d);
      OUT_READY = (hold == 0);
      DATA_IN   = d;
      IN_VALID  = 1'b1;
      tick();                       // capture edge T
      IN_VALID  = 1'b0;
      DATA_IN   = W'($urandom);     // later changes must not matter
      check({tag, "_inready_busy"}, 32'(IN_READY), 32'd0);
      k = 0;
      while (!OUT_VALID && k < 40) begin
         tick();
         k++;
      end
      // OUT_VALID goes high right after edge T+W+1
      check({tag, "_latency"}, 32'(k), 32'(W + 1));
      check({tag, "_data"}, 32'(DATA_OUT), 32'(exp[W-1:0]));
      check({tag, "_ovf"}, 32'(OVF), 32'(exp[W]));
      held = DATA_OUT;
      for (int i = 0; i < hold; i++) begin
         IN_VALID = 1'b1;
         DATA_IN  = W'($urandom);
         tick();
         check({tag, "_hold_valid"}, 32'(OUT_VALID), 32'd1);
         check({tag, "_hold_data"}, 32'(DATA_OUT), 32'(held));
         check({tag, "_hold_inready"}, 32'(IN_READY), 32'd0);
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      tick();
      check({tag, "_release_valid"}, 32'(OUT_VALID), 32'd0);
      check({tag, "_release_idle"}, 32'(IN_READY), 32'd1);
   endtask

   initial begin
      logic [W-1:0] ops [256];
      logic [W-1:0] tmp;
      int           j;
      int           saw_valid;

      RESET     = 1'b0;
      IN_VALID  = 1'b0;
      DATA_IN   = '0;
      OUT_READY = 1'b1;
      tick();
      tick();
      check("rst_inready", 32'(IN_READY), 32'd1);
      check("rst_outvalid", 32'(OUT_VALID), 32'd0);
      check("rst_data", 32'(DATA_OUT), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);
      RESET = 1'b1;
      tick();

      // directed operands
      run_op(8'h05, 0, "pos5");
      run_op(8'hFE, 0, "neg2");
      run_op(8'h81, 0, "neg127");
      run_op(8'h00, 0, "zero");
      run_op(8'h80, 0, "mostneg");
      run_op(8'h7F, 0, "pos127");
      run_op(8'hFF, 0, "neg1");
      // backpressure with stray IN_VALID
      run_op(8'hC3, 5, "bp");

      // reset in the 4th SHIFT cycle of 8'hF0
      DATA_IN  = 8'hF0;
      IN_VALID = 1'b1;
      tick();                       // capture
      IN_VALID = 1'b0;
      tick();
      tick();
      tick();                       // now inside the 4th SHIFT cycle
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      check("abort_inready", 32'(IN_READY), 32'd1);
      check("abort_valid", 32'(OUT_VALID), 32'd0);
      check("abort_data", 32'(DATA_OUT), 32'd0);
      check("abort_ovf", 32'(OVF), 32'd0);
      saw_valid = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (OUT_VALID) saw_valid++;
      end
      check("abort_no_valid", 32'(saw_valid), 32'd0);
      run_op(8'h03, 0, "after_abort");

      // reset wins over simultaneous IN_VALID
      RESET    = 1'b0;
      IN_VALID = 1'b1;
      DATA_IN  = 8'h44;
      tick();
      RESET    = 1'b1;
      IN_VALID = 1'b0;
      tick();
      check("rst_vs_valid_idle", 32'(IN_READY), 32'd1);
      check("rst_vs_valid_novalid", 32'(OUT_VALID), 32'd0);

      // shuffled sweep of every operand
      for (int i = 0; i < 256; i++) ops[i] = W'(i);
      for (int i = 255; i > 0; i--) begin
         j      = int'($urandom_range(i, 0));
         tmp    = ops[i];
         ops[i] = ops[j];
         ops[j] = tmp;
      end
      for (int i = 0; i < 256; i++)
         run_op(ops[i], int'($urandom_range(2, 0)), "sweep");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
